rs232_receiver: RTL and testbench
=================================

RS232_RECEIVER -- requirements
Module: rs232_receiver

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 Parameter BAUD_RATE, default 19200, serial bit rate.
REQ-003 Parameter CLKS_PER_BIT, default CLK_FREQ_HZ/BAUD_RATE (5208), clock cycles per serial bit; the value is truncated.
REQ-004 clk  input  1  single system clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 data  output  8  last correctly received byte.
REQ-008 data_ready  output  1  one-cycle pulse when data holds a new byte.
REQ-009 error  output  1  one-cycle pulse on a framing error.

Function
REQ-010 The frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), no parity.
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; the 2-cycle latency is part of all timing below.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: a synchronized rx of 0 SHALL move to START and clear the bit counter.
REQ-014 START: at CLKS_PER_BIT/2 cycles, synchronized rx SHALL be sampled.
- If it is 0, go to DATA.
- If it is 1 (glitch), return to IDLE with no output activity.
REQ-015 DATA: each bit SHALL be sampled CLKS_PER_BIT cycles after the previous sample (mid-bit).
- Bit i is stored into shift register position i.
- After bit 7, go to STOP.
REQ-016 STOP: the line SHALL be sampled CLKS_PER_BIT cycles after data bit 7.
- If 1: load data from the shift register, pulse data_ready for exactly one cycle, go to IDLE.
- If 0: pulse error for exactly one cycle, leave data unchanged, go to WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL stay until synchronized rx is 1, then go to IDLE, so a break or stuck-low line produces no further frames.
REQ-018 data_ready and error SHALL never be asserted in the same cycle.
REQ-019 data SHALL hold its value between frames and change only in the data_ready cycle.
REQ-020 The bit timer SHALL be wide enough for CLKS_PER_BIT-1 (13 bits at default) and SHALL restart at 0 on every state transition.
REQ-021 A falling edge on rx during STOP sampling or in IDLE in the cycle after a frame completes SHALL be accepted as a new start bit, so back-to-back frames are supported.

Reset
REQ-022 While rst is high, the following SHALL be set asynchronously:
- state=IDLE
- data=8'h00, data_ready=0, error=0
- shift register, bit counter and bit timer = 0
- synchronizer flops = 1
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; the next full frame after release SHALL be received correctly.

Structure
REQ-024 A shared package SHALL hold the state enumeration type and the default CLK_FREQ_HZ/BAUD_RATE constants.
REQ-025 One sub-module, rs232_bit_timer, SHALL provide the CLKS_PER_BIT cycle counter with restart input and half-bit and full-bit terminal-count outputs.
REQ-026 The synchronizer and FSM SHALL remain in rs232_receiver.

Verification
Benches use a 10 ns clk period and a 52080 ns bit period.
REQ-027 rx=1 for 200 ns, then frame 0x6A (bits 0,1,0,1,0,1,1,0) with stop 1 -> exactly one data_ready pulse near mid-stop-bit, data=8'h6A, error stays 0.
REQ-028 Frame 0x3C with stop bit 0 -> one error pulse, no data_ready, data keeps its previous value; rx held low 5 bit times -> no further pulses until rx returns high.
REQ-029 rx low for 1000 ns then high -> no data_ready, no error, FSM back in IDLE.
REQ-030 Back-to-back frames 0x00 then 0xFF with one stop bit each -> two data_ready pulses, data=8'h00 then 8'hFF.
REQ-031 rst pulsed during data bit 3 of a frame -> all outputs 0 during reset, no pulse for that frame; next frame 0xA5 -> data=8'hA5 with one data_ready pulse.
REQ-032 Bit period skewed ±2% on frame 0x55 -> data=8'h55 received without error.

Source files
------------

// File: rtl/rs232_receiver_pkg.sv
// Shared types and default constants for the RS-232 receiver.
`timescale 1ns/1ps
package rs232_receiver_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   localparam int DEF_CLK_FREQ_HZ = 100_000_000;
   localparam int DEF_BAUD_RATE   = 19200;

endpackage

// File: rtl/rs232_bit_timer.sv
// Free-running bit-period counter with half-bit and full-bit terminal counts.
`timescale 1ns/1ps
module rs232_bit_timer #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic half_tc,
   output logic full_tc
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
   localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

   logic [W-1:0] cnt;

   assign half_tc = (cnt == HALF);
   assign full_tc = (cnt == FULL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || full_tc) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/rs232_receiver.sv
// 8N1 serial receiver: rx synchronizer, framing FSM and output registers.
`timescale 1ns/1ps
module rs232_receiver
   import rs232_receiver_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
   parameter int BAUD_RATE    = DEF_BAUD_RATE,
   parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       error
);

   rx_state_t  state, state_next;
   logic       rx_meta, rx_sync;
   logic [2:0] bit_cnt, bit_cnt_next;
   logic [7:0] shift, shift_next;
   logic [7:0] data_next;
   logic       ready_next, error_next;
   logic       restart, half_tc, full_tc;

   // Timer realigns on every state change so samples land mid-bit.
   assign restart = (state_next != state);

   rs232_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .half_tc(half_tc),
      .full_tc(full_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      data_next    = data;
      ready_next   = 1'b0;
      error_next   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_sync) begin
               state_next   = START;
               bit_cnt_next = '0;
            end
         end
         START: begin
            if (half_tc) begin
               state_next = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (full_tc) begin
               shift_next[bit_cnt] = rx_sync;
               if (bit_cnt == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            if (full_tc) begin
               if (rx_sync) begin
                  data_next  = shift;
                  ready_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  error_next = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_sync) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         data       <= '0;
         data_ready <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_next;
         bit_cnt    <= bit_cnt_next;
         shift      <= shift_next;
         data       <= data_next;
         data_ready <= ready_next;
         error      <= error_next;
      end
   end

endmodule

// File: tb/tb_rs232_receiver.sv
// Directed bench for rs232_receiver with immediate-assertion checks.
`timescale 1ns/1ps
module tb_rs232_receiver;
   import rs232_receiver_pkg::*;

   // Scaled bit period (256 clocks) keeps the run short.
   localparam int CPB    = 256;
   localparam int BIT_NS = CPB * 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       data_ready;
   logic       error;

   int vectors    = 0;
   int miscompares = 0;

   int         rdy_cnt = 0;
   int         err_cnt = 0;
   int         overlap = 0;
   int         bad_chg = 0;
   logic [7:0] rdy_log [0:31];
   logic [7:0] prev_data = 8'h00;
   time        rdy_time = 0;

   int   r0, e0;
   time  stop_t;

   always #5 clk = ~clk;

   rs232_receiver #(
      .CLK_FREQ_HZ (100_000_000),
      .BAUD_RATE   (390_625),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .data_ready(data_ready),
      .error     (error)
   );

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (data_ready) begin
            if (rdy_cnt < 32) rdy_log[rdy_cnt] = data;
            rdy_cnt  = rdy_cnt + 1;
            rdy_time = $time;
         end
         if (error) err_cnt = err_cnt + 1;
         if (data_ready && error) overlap = overlap + 1;
         if (data !== prev_data && !data_ready) bad_chg = bad_chg + 1;
      end
      prev_data = data;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int bit_ns, output time st);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      st = $time;
      rx = stop;
      #(bit_ns);
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data), 32'h00);
      check("rst_ready", 32'(data_ready), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      rst = 1'b0;
      #200;

      // 0x6A, good stop bit
      r0 = rdy_cnt; e0 = err_cnt;
      send_frame(8'h6A, 1'b1, BIT_NS, stop_t);
      #(2 * BIT_NS);
      check("6a_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check("6a_err_cnt", 32'(err_cnt - e0), 32'd0);
      check("6a_data", 32'(data), 32'h6A);
      check("6a_mid_stop",
            32'((rdy_time > stop_t) && (rdy_time < stop_t + BIT_NS)), 32'd1);

      // 0x3C, stop bit low, line held low 5 bit times
      r0 = rdy_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0, BIT_NS, stop_t);
      #(4 * BIT_NS);
      check("3c_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("3c_ready_cnt", 32'(rdy_cnt - r0), 32'd0);
      check("3c_data_kept", 32'(data), 32'h6A);
      check("3c_wait_idle", 32'(dut.state), 32'(WAIT_IDLE));
      rx = 1'b1;
      #(2 * BIT_NS);
      check("brk_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("brk_ready_cnt", 32'(rdy_cnt - r0), 32'd0);
      check("brk_idle", 32'(dut.state), 32'(IDLE));

      // short low glitch
      r0 = rdy_cnt; e0 = err_cnt;
      rx = 1'b0;
      #1000;
      rx = 1'b1;
      #(2 * BIT_NS);
      check("glitch_ready", 32'(rdy_cnt - r0), 32'd0);
      check("glitch_err", 32'(err_cnt - e0), 32'd0);
      check("glitch_idle", 32'(dut.state), 32'(IDLE));

      // back-to-back 0x00, 0xFF
      r0 = rdy_cnt; e0 = err_cnt;
      send_frame(8'h00, 1'b1, BIT_NS, stop_t);
      send_frame(8'hFF, 1'b1, BIT_NS, stop_t);
      #(2 * BIT_NS);
      check("b2b_ready_cnt", 32'(rdy_cnt - r0), 32'd2);
      check("b2b_err_cnt", 32'(err_cnt - e0), 32'd0);
      check("b2b_first", 32'(rdy_log[r0]), 32'h00);
      check("b2b_second", 32'(rdy_log[r0 + 1]), 32'hFF);
      check("b2b_data", 32'(data), 32'hFF);

      // reset during data bit 3 of 0xF8, then 0xA5
      r0 = rdy_cnt; e0 = err_cnt;
      rx = 1'b0;
      #(4 * BIT_NS);
      rx = 1'b1;
      #(BIT_NS / 2);
      rst = 1'b1;
      #100;
      check("mid_rst_data", 32'(data), 32'h00);
      check("mid_rst_ready", 32'(data_ready), 32'h0);
      check("mid_rst_error", 32'(error), 32'h0);
      check("mid_rst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      #(BIT_NS / 2 - 100);
      #(6 * BIT_NS);
      check("abort_ready", 32'(rdy_cnt - r0), 32'd0);
      check("abort_err", 32'(err_cnt - e0), 32'd0);
      send_frame(8'hA5, 1'b1, BIT_NS, stop_t);
      #(2 * BIT_NS);
      check("a5_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check("a5_err_cnt", 32'(err_cnt - e0), 32'd0);
      check("a5_data", 32'(data), 32'hA5);

      // 0x55 with bit period 2% slow, then 2% fast
      r0 = rdy_cnt; e0 = err_cnt;
      send_frame(8'h55, 1'b1, (BIT_NS * 102) / 100, stop_t);
      #(2 * BIT_NS);
      check("slow_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check("slow_data", 32'(data), 32'h55);
      send_frame(8'hAA, 1'b1, BIT_NS, stop_t);
      #(BIT_NS);
      r0 = rdy_cnt;
      send_frame(8'h55, 1'b1, (BIT_NS * 98) / 100, stop_t);
      #(2 * BIT_NS);
      check("fast_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check("fast_data", 32'(data), 32'h55);
      check("skew_err_cnt", 32'(err_cnt - e0), 32'd0);

      check("ready_error_overlap", 32'(overlap), 32'd0);
      check("data_change_outside_ready", 32'(bad_chg), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
